bbpd_voter: RTL and testbench

- Bang-bang (Alexander) phase-detector decision block in the Rx CDR/PLL.
- Consumes per-UI data and edge samples from the slicers and produces the up/dn pulses that drive the digital loop filter.
- Accumulates signed early/late votes over a fixed window and emits at most one decision pulse per window.
- Decimation sets the PD update rate and gain seen by the loop filter.

---
 rtl/bbpd_voter_if.sv | 41 ++++
 rtl/bbpd_voter.sv | 133 +++++++++++++
 tb/tb_bbpd_voter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bbpd_voter_if.sv
// Sample/decision bundle between the data/edge slicers and the bang-bang PD voter.
// With BBPD_STATS_EN defined, it also carries the saturating statistics counters.
interface bbpd_voter_if #(
    parameter int unsigned Nw = 8
`ifdef BBPD_STATS_EN
    , parameter int unsigned Ncnt = 16
`endif
);
    localparam int unsigned VoteW = $clog2(Nw + 1) + 1;

    logic                    en;
    logic                    d;
    logic                    e;
    logic                    up;
    logic                    dn;
    logic                    win_done;
    logic signed [VoteW-1:0] vote;
`ifdef BBPD_STATS_EN
    logic [Ncnt-1:0]         up_cnt;
    logic [Ncnt-1:0]         dn_cnt;
    logic [Ncnt-1:0]         trans_cnt;

    modport master (
        output en, d, e,
        input  up, dn, win_done, vote, up_cnt, dn_cnt, trans_cnt
    );
    modport slave (
        input  en, d, e,
        output up, dn, win_done, vote, up_cnt, dn_cnt, trans_cnt
    );
`else
    modport master (
        output en, d, e,
        input  up, dn, win_done, vote
    );
    modport slave (
        input  en, d, e,
        output up, dn, win_done, vote
    );
`endif
endinterface

// File: rtl/bbpd_voter.sv
// Bang-bang (Alexander) PD voter: sums early/late votes over Nw valid samples, one up/dn per window.
// Optional BBPD_STATS_EN adds saturating up/dn/transition counters.
module bbpd_voter #(
    parameter int unsigned Nw   = 8,
    parameter int unsigned Nth  = 0,
    parameter int unsigned Ncnt = 16
) (
    input  logic          clk,
    input  logic          rst,
    bbpd_voter_if.slave   bus
);
    localparam int unsigned VoteW  = $clog2(Nw + 1) + 1;
    localparam int unsigned WcntW  = $clog2(Nw);
    localparam logic [WcntW-1:0] WcntLast = WcntW'(Nw - 1);
    localparam logic signed [VoteW-1:0] NthPos = VoteW'(Nth);
    localparam logic signed [VoteW-1:0] NthNeg = -NthPos;

    if (Nw < 2 || Nth >= Nw || Ncnt < 1) begin : g_param_check
        $error("bbpd_voter: illegal parameter combination");
    end

    logic signed [VoteW-1:0] acc_q, acc_d;
    logic signed [VoteW-1:0] vote_q, vote_d;
    logic [WcntW-1:0]        wcnt_q, wcnt_d;
    logic                    d_prev_q, d_prev_d;
    logic                    prev_valid_q, prev_valid_d;
    logic                    up_q, up_d;
    logic                    dn_q, dn_d;
    logic                    win_done_q, win_done_d;

    logic signed [VoteW-1:0] vote_i;
    logic signed [VoteW-1:0] total;

    // A transition means e matches exactly one neighbour: e==d is late, e==d_prev is early.
    always_comb begin
        vote_i = '0;
        if (prev_valid_q && (bus.d != d_prev_q)) begin
            vote_i = (bus.e == bus.d) ? VoteW'(1) : '1;
        end
        total = acc_q + vote_i;
    end

    always_comb begin
        acc_d        = acc_q;
        vote_d       = vote_q;
        wcnt_d       = wcnt_q;
        d_prev_d     = d_prev_q;
        prev_valid_d = prev_valid_q;
        up_d         = 1'b0;
        dn_d         = 1'b0;
        win_done_d   = 1'b0;
        if (bus.en) begin
            d_prev_d     = bus.d;
            prev_valid_d = 1'b1;
            if (wcnt_q == WcntLast) begin
                wcnt_d     = '0;
                acc_d      = '0;
                vote_d     = total;
                win_done_d = 1'b1;
                up_d       = (total > NthPos);
                dn_d       = (total < NthNeg);
            end else begin
                wcnt_d = wcnt_q + WcntW'(1);
                acc_d  = total;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            vote_q       <= '0;
            wcnt_q       <= '0;
            d_prev_q     <= 1'b0;
            prev_valid_q <= 1'b0;
            up_q         <= 1'b0;
            dn_q         <= 1'b0;
            win_done_q   <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            vote_q       <= vote_d;
            wcnt_q       <= wcnt_d;
            d_prev_q     <= d_prev_d;
            prev_valid_q <= prev_valid_d;
            up_q         <= up_d;
            dn_q         <= dn_d;
            win_done_q   <= win_done_d;
        end
    end

    assign bus.up       = up_q;
    assign bus.dn       = dn_q;
    assign bus.win_done = win_done_q;
    assign bus.vote     = vote_q;

`ifdef BBPD_STATS_EN
    logic [Ncnt-1:0] up_cnt_q, up_cnt_d;
    logic [Ncnt-1:0] dn_cnt_q, dn_cnt_d;
    logic [Ncnt-1:0] trans_cnt_q, trans_cnt_d;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        up_cnt_d    = up_cnt_q;
        dn_cnt_d    = dn_cnt_q;
        trans_cnt_d = trans_cnt_q;
        if (up_d && !(&up_cnt_q)) begin
            up_cnt_d = up_cnt_q + Ncnt'(1);
        end
        if (dn_d && !(&dn_cnt_q)) begin
            dn_cnt_d = dn_cnt_q + Ncnt'(1);
        end
        if (bus.en && (vote_i != '0) && !(&trans_cnt_q)) begin
            trans_cnt_d = trans_cnt_q + Ncnt'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            up_cnt_q    <= '0;
            dn_cnt_q    <= '0;
            trans_cnt_q <= '0;
        end else begin
            up_cnt_q    <= up_cnt_d;
            dn_cnt_q    <= dn_cnt_d;
            trans_cnt_q <= trans_cnt_d;
        end
    end

    assign bus.up_cnt    = up_cnt_q;
    assign bus.dn_cnt    = dn_cnt_q;
    assign bus.trans_cnt = trans_cnt_q;
`endif
endmodule

// File: tb/tb_bbpd_voter.sv
// Directed bench for bbpd_voter: two instances (Nth=0 and Nth=2) fed the same sample stream.
// Covers counter checks when compiled with BBPD_STATS_EN.
module tb_bbpd_voter;
    logic clk;
    logic rst;

    bbpd_voter_if #(.Nw(8)) if0 ();
    bbpd_voter_if #(.Nw(8)) if2 ();

    bbpd_voter #(.Nw(8), .Nth(0), .Ncnt(16)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    bbpd_voter #(.Nw(8), .Nth(2), .Ncnt(16)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic rst;
        logic en;
        logic d;
        logic e;
        logic up;
        logic dn;
        logic up2;
        logic dn2;
        logic wd;
        int   vote;
    } vec_t;

    vec_t vecs[$];
    int   total;
    int   bad;

    task automatic add(input logic r, input logic en, input logic d, input logic e,
                       input logic up, input logic dn, input logic up2, input logic dn2,
                       input logic wd, input int vote);
        vec_t v;
        v.rst = r;  v.en = en;  v.d = d;    v.e = e;
        v.up = up;  v.dn = dn;  v.up2 = up2; v.dn2 = dn2;
        v.wd = wd;  v.vote = vote;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic en, input logic d, input logic e);
        rst    = r;
        if0.en = en; if0.d = d; if0.e = e;
        if2.en = en; if2.d = d; if2.e = e;
    endtask

    task automatic step(input logic r, input logic en, input logic d, input logic e);
        @(negedge clk);
        drive(r, en, d, e);
        @(posedge clk);
        #1;
    endtask

    logic dv;
    logic last;
    int   vexp;

    initial begin
        total = 0;
        bad   = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);

        // Late-only: +7 first window (first sample unvoted), +8 next.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            dv   = i[0];
            last = (i == 7) || (i == 15);
            vexp = (i < 7) ? 0 : (i < 15) ? 7 : 8;
            add(0, 1, dv, dv, last, 0, last, 0, last, vexp);
        end
        // Early-only: -7 then -8.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            dv   = i[0];
            last = (i == 7) || (i == 15);
            vexp = (i < 7) ? 0 : (i < 15) ? -7 : -8;
            add(0, 1, dv, ~dv, 0, last, 0, last, last, vexp);
        end
        // Constant data: no transitions, windows still close.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            last = (i == 7) || (i == 15);
            add(0, 1, 1'b1, i[0], 0, 0, 0, 0, last, 0);
        end
        // Alternating late/early: +1 then 0; Nth=0 fires up on +1, Nth=2 never fires.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            dv   = i[0];
            last = (i == 7) || (i == 15);
            vexp = (i < 7) ? 0 : (i < 15) ? 1 : 0;
            add(0, 1, dv, 1'b1, (i == 7), 0, 0, 0, last, vexp);
        end
        // Warm-up window, then a late-only window with a 5-cycle en gap.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            dv   = i[0];
            last = (i == 7);
            add(0, 1, dv, dv, last, 0, last, 0, last, (i == 7) ? 7 : 0);
        end
        for (int i = 8; i < 12; i++) begin
            dv = i[0];
            add(0, 1, dv, dv, 0, 0, 0, 0, 0, 7);
        end
        for (int i = 0; i < 5; i++) begin
            add(0, 0, 1'b0, i[0], 0, 0, 0, 0, 0, 7);
        end
        for (int i = 12; i < 16; i++) begin
            dv   = i[0];
            last = (i == 15);
            add(0, 1, dv, dv, last, 0, last, 0, last, last ? 8 : 7);
        end

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].d, vecs[i].e);
            chk($sformatf("vec%0d up", i),    if0.up,       vecs[i].up);
            chk($sformatf("vec%0d dn", i),    if0.dn,       vecs[i].dn);
            chk($sformatf("vec%0d wd", i),    if0.win_done, vecs[i].wd);
            chk($sformatf("vec%0d vote", i),  if0.vote,     vecs[i].vote);
            chk($sformatf("vec%0d up2", i),   if2.up,       vecs[i].up2);
            chk($sformatf("vec%0d dn2", i),   if2.dn,       vecs[i].dn2);
            chk($sformatf("vec%0d wd2", i),   if2.win_done, vecs[i].wd);
            chk($sformatf("vec%0d vote2", i), if2.vote,     vecs[i].vote);
        end

        // Mid-window reset: four late samples, then rst (with en high) at sample 4.
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, i[0] ? 1'b1 : 1'b0, i[0] ? 1'b1 : 1'b0);
            chk($sformatf("pre_rst%0d wd", i), if0.win_done, 0);
        end
`ifdef BBPD_STATS_EN
        chk("pre_rst up_cnt",    if0.up_cnt,    2);
        chk("pre_rst dn_cnt",    if0.dn_cnt,    0);
        chk("pre_rst trans_cnt", if0.trans_cnt, 19);
`endif
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("rst up",   if0.up,       0);
        chk("rst dn",   if0.dn,       0);
        chk("rst wd",   if0.win_done, 0);
        chk("rst vote", if0.vote,     0);
`ifdef BBPD_STATS_EN
        chk("rst up_cnt",    if0.up_cnt,    0);
        chk("rst trans_cnt", if0.trans_cnt, 0);
`endif
        for (int i = 0; i < 8; i++) begin
            dv = i[0];
            step(1'b0, 1'b1, dv, dv);
            chk($sformatf("post_rst%0d wd", i),   if0.win_done, (i == 7) ? 1 : 0);
            chk($sformatf("post_rst%0d up", i),   if0.up,       (i == 7) ? 1 : 0);
            chk($sformatf("post_rst%0d vote", i), if0.vote,     (i == 7) ? 7 : 0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("pulse_end wd",   if0.win_done, 0);
        chk("pulse_end up",   if0.up,       0);
        chk("pulse_end vote", if0.vote,     7);
`ifdef BBPD_STATS_EN
        chk("post_rst up_cnt",    if0.up_cnt,    1);
        chk("post_rst dn_cnt",    if0.dn_cnt,    0);
        chk("post_rst trans_cnt", if0.trans_cnt, 7);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
